// File: rtl/jpeg_line_fifo_fwft.sv
// Line-tagged first-word-fall-through FIFO for the JPEG line buffer path.
// Optional sticky overflow/underflow flags are built when JPEG_LINE_FIFO_ERR_EN is defined.
module jpeg_line_fifo_fwft #(
    parameter int c_DATA_WIDTH       = 32,
    parameter int c_DEPTH_WIDTH      = 10,
    parameter int c_ALMOST_FULL_NUM  = 1020,
    parameter int c_ALMOST_EMPTY_NUM = 4,
    parameter int c_LINE_THRESH      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic [c_DATA_WIDTH-1:0]  wr_data,
    input  logic                     wr_en,
    input  logic                     wr_eol,
    output logic                     wr_full,
    output logic                     almost_full,
    output logic [c_DATA_WIDTH-1:0]  rd_data,
    output logic                     rd_eol,
    input  logic                     rd_en,
    output logic                     rd_empty,
    output logic                     almost_empty,
    output logic [c_DEPTH_WIDTH:0]   water_level,
    output logic [c_DEPTH_WIDTH:0]   line_cnt,
    output logic                     lines_ready,
    output logic                     ovf_err,
    output logic                     udf_err
);

    localparam int DEPTH = 1 << c_DEPTH_WIDTH;
    localparam int LW    = c_DEPTH_WIDTH + 1;

    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AF_LVL   = LW'(c_ALMOST_FULL_NUM);
    localparam logic [LW-1:0] AE_LVL   = LW'(c_ALMOST_EMPTY_NUM);
    localparam logic [LW-1:0] LINE_LVL = LW'(c_LINE_THRESH);

    typedef struct packed {
        logic                    eol;
        logic [c_DATA_WIDTH-1:0] data;
    } word_t;

    word_t mem_q [DEPTH];

    logic [c_DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]            level_q, level_d;
    logic [LW-1:0]            lines_q, lines_d;
    logic                     head_vld_q, head_vld_d;
    word_t                    head_q, head_d;

    logic          wr_acc, rd_acc, load;
    logic [LW-1:0] mem_cnt;

    // level counts the head register too, so the memory holds level minus head
    assign mem_cnt = level_q - LW'(head_vld_q);
    assign wr_acc  = wr_en & ~wr_full;
    assign rd_acc  = rd_en & head_vld_q;
    assign load    = (mem_cnt != '0) & (~head_vld_q | rd_acc);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        lines_d    = lines_q;
        head_vld_d = head_vld_q;
        head_d     = head_q;
        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            lines_d    = '0;
            head_vld_d = 1'b0;
            head_d     = '0;
        end else begin
            if (wr_acc)
                wr_ptr_d = wr_ptr_q + c_DEPTH_WIDTH'(1);
            if (load) begin
                head_d     = mem_q[rd_ptr_q];
                head_vld_d = 1'b1;
                rd_ptr_d   = rd_ptr_q + c_DEPTH_WIDTH'(1);
            end else if (rd_acc) begin
                head_vld_d = 1'b0;
            end
            level_d = level_q + LW'(wr_acc) - LW'(rd_acc);
            lines_d = lines_q + LW'(wr_acc & wr_eol) - LW'(rd_acc & head_q.eol);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            lines_q    <= '0;
            head_vld_q <= 1'b0;
            head_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            lines_q    <= lines_d;
            head_vld_q <= head_vld_d;
            head_q     <= head_d;
        end
    end

    // Storage is never reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc && !clr)
            mem_q[wr_ptr_q] <= {wr_eol, wr_data};
    end

    assign wr_full      = (level_q == FULL_LVL);
    assign almost_full  = (level_q >= AF_LVL);
    assign almost_empty = (level_q <= AE_LVL);
    assign rd_empty     = ~head_vld_q;
    assign rd_data      = head_q.data;
    assign rd_eol       = head_q.eol;
    assign water_level  = level_q;
    assign line_cnt     = lines_q;
    assign lines_ready  = (lines_q >= LINE_LVL);

`ifdef JPEG_LINE_FIFO_ERR_EN
    logic ovf_q, ovf_d, udf_q, udf_d;

    // A read paired with a write on an empty FIFO is not an underflow.
    always_comb begin
        ovf_d = ovf_q | (wr_en & wr_full);
        udf_d = udf_q | (rd_en & rd_empty & ~wr_en);
        if (clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf_err = ovf_q;
    assign udf_err = udf_q;
`else
    assign ovf_err = 1'b0;
    assign udf_err = 1'b0;
`endif

endmodule

// File: tb/tb_jpeg_line_fifo_fwft.sv
// Bench for jpeg_line_fifo_fwft: constant vector table, corner sequences, and a
// randomized stream checked against a queue model of stored words.
module tb_jpeg_line_fifo_fwft;

    localparam int DEPTH = 1024;
    localparam int AF    = 1020;
    localparam int AE    = 4;
    localparam int LT    = 8;

    logic        clk = 1'b0;
    logic        rst_n, clr, wr_en, wr_eol, rd_en;
    logic [31:0] wr_data;
    logic        wr_full, almost_full, rd_eol, rd_empty, almost_empty;
    logic [31:0] rd_data;
    logic [10:0] water_level, line_cnt;
    logic        lines_ready, ovf_err, udf_err;

    jpeg_line_fifo_fwft dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .wr_data(wr_data), .wr_en(wr_en), .wr_eol(wr_eol),
        .wr_full(wr_full), .almost_full(almost_full),
        .rd_data(rd_data), .rd_eol(rd_eol), .rd_en(rd_en),
        .rd_empty(rd_empty), .almost_empty(almost_empty),
        .water_level(water_level), .line_cnt(line_cnt),
        .lines_ready(lines_ready), .ovf_err(ovf_err), .udf_err(udf_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

`ifdef JPEG_LINE_FIFO_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Model: a word is stored from its write edge, and becomes readable at the
    // head only after one further edge has passed.
    typedef struct {
        logic        eol;
        logic [31:0] data;
        int unsigned wedge;
    } mw_t;

    mw_t         q[$];
    int unsigned edge_n = 0;
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;

    function automatic logic m_empty();
        return (q.size() == 0) || (q[0].wedge == edge_n);
    endfunction

    function automatic int m_lines();
        int n = 0;
        foreach (q[i]) if (q[i].eol) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int   lv;
        int   ln;
        logic e;
        lv = q.size();
        ln = m_lines();
        e  = m_empty();
        chk("water_level", water_level, lv);
        chk("wr_full", wr_full, lv == DEPTH);
        chk("almost_full", almost_full, lv >= AF);
        chk("almost_empty", almost_empty, lv <= AE);
        chk("rd_empty", rd_empty, e);
        chk("line_cnt", line_cnt, ln);
        chk("lines_ready", lines_ready, ln >= LT);
        chk("ovf_err", ovf_err, m_ovf);
        chk("udf_err", udf_err, m_udf);
        if (!e) begin
            chk("rd_data", rd_data, q[0].data);
            chk("rd_eol", rd_eol, q[0].eol);
        end
    endtask

    task automatic cyc(input logic c, input logic w, input logic r, input logic eo,
                       input logic [31:0] d);
        logic pre_empty, pre_full;
        clr = c; wr_en = w; rd_en = r; wr_eol = eo; wr_data = d;
        pre_empty = m_empty();
        pre_full  = (q.size() == DEPTH);
        @(posedge clk);
        edge_n++;
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (r && !pre_empty) void'(q.pop_front());
            if (w && !pre_full) q.push_back('{eo, d, edge_n});
            if (ERR_EN && w && pre_full) m_ovf = 1'b1;
            if (ERR_EN && r && pre_empty && !w) m_udf = 1'b1;
        end
        #1;
        check_model();
    endtask

    typedef struct {
        logic        c, w, r, eo;
        logic [31:0] d;
        int          lvl;
        logic        emp;
        int          lines;
        logic [31:0] rdd;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int  pushed;
        bit  did_clr;
        logic w, r;

        tbl[0]  = '{0, 1, 0, 0, 32'hA5A5A5A5, 1, 1, 0, 32'h0};
        tbl[1]  = '{0, 0, 0, 0, 32'h0,        1, 0, 0, 32'hA5A5A5A5};
        tbl[2]  = '{0, 1, 0, 1, 32'h00000011, 2, 0, 1, 32'hA5A5A5A5};
        tbl[3]  = '{0, 0, 1, 0, 32'h0,        1, 0, 1, 32'h00000011};
        tbl[4]  = '{0, 1, 1, 0, 32'h00000022, 1, 1, 0, 32'h0};
        tbl[5]  = '{0, 0, 1, 0, 32'h0,        1, 0, 0, 32'h00000022};
        tbl[6]  = '{0, 1, 1, 1, 32'h00000033, 1, 1, 1, 32'h0};
        tbl[7]  = '{1, 1, 0, 1, 32'h00000055, 0, 1, 0, 32'h0};
        tbl[8]  = '{0, 1, 1, 0, 32'h00000044, 1, 1, 0, 32'h0};
        tbl[9]  = '{0, 0, 0, 0, 32'h0,        1, 0, 0, 32'h00000044};
        tbl[10] = '{0, 0, 1, 0, 32'h0,        0, 1, 0, 32'h0};

        rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_eol = 1'b0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_water_level", water_level, 0);
        chk("rst_line_cnt", line_cnt, 0);
        chk("rst_rd_empty", rd_empty, 1);
        chk("rst_wr_full", wr_full, 0);
        chk("rst_almost_empty", almost_empty, 1);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_lines_ready", lines_ready, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_eol", rd_eol, 0);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_udf", udf_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: short hand-computed sequence from reset
        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].c, tbl[i].w, tbl[i].r, tbl[i].eo, tbl[i].d);
            chk("tbl_level", water_level, tbl[i].lvl);
            chk("tbl_empty", rd_empty, tbl[i].emp);
            chk("tbl_lines", line_cnt, tbl[i].lines);
            if (!tbl[i].emp) chk("tbl_rd_data", rd_data, tbl[i].rdd);
        end

        // Fill to capacity, then one extra write
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, 0, 32'h1000 + i);
        chk("fill_full", wr_full, 1);
        chk("fill_level", water_level, DEPTH);
        cyc(0, 1, 0, 0, 32'hDEADBEEF);
        chk("over_full", wr_full, 1);
        chk("over_level", water_level, DEPTH);
        chk("over_ovf", ovf_err, ERR_EN);

        // Full with both requests: read only
        cyc(0, 1, 1, 0, 32'hBEEF0000);
        chk("fullboth_level", water_level, DEPTH - 1);
        chk("fullboth_full", wr_full, 0);
        chk("fullboth_head", rd_data, 32'h1001);

        for (int i = 0; i < 1100 && q.size() > 0; i++) cyc(0, 0, 1, 0, 32'h0);
        chk("drain_level", water_level, 0);
        chk("drain_empty", rd_empty, 1);

        // Empty with both requests: write only, no underflow
        cyc(0, 1, 1, 0, 32'h55550001);
        chk("emptyboth_level", water_level, 1);
        chk("emptyboth_udf", udf_err, 0);
        cyc(0, 0, 0, 0, 32'h0);
        chk("emptyboth_head", rd_data, 32'h55550001);
        cyc(1, 0, 0, 0, 32'h0);

        // Eight 16-word lines, then pop one line
        for (int l = 0; l < 8; l++)
            for (int k = 0; k < 16; k++)
                cyc(0, 1, 0, k == 15, {16'(l), 16'(k)});
        cyc(0, 0, 0, 0, 32'h0);
        chk("lines8_cnt", line_cnt, 8);
        chk("lines8_ready", lines_ready, 1);
        for (int k = 0; k < 16; k++) cyc(0, 0, 1, 0, 32'h0);
        chk("lines7_cnt", line_cnt, 7);
        chk("lines7_ready", lines_ready, 0);
        chk("lines7_level", water_level, 112);
        cyc(1, 0, 0, 0, 32'h0);

        // Random stream across pointer wrap, with a flush in the middle
        pushed = 0;
        did_clr = 1'b0;
        for (int cy = 0; cy < 20000 && pushed < 3000; cy++) begin
            w = ($urandom_range(0, 99) < 60);
            r = ($urandom_range(0, 99) < 55);
            if (pushed >= 1500 && !did_clr) begin
                did_clr = 1'b1;
                cyc(1, w, r, 1'b0, $urandom);
                chk("clr_level", water_level, 0);
                chk("clr_empty", rd_empty, 1);
            end else begin
                if (w && q.size() < DEPTH) pushed++;
                cyc(0, w, r, ($urandom_range(0, 7) == 0), $urandom);
            end
        end
        checks++;
        if (pushed < 3000) begin
            errors++;
            $display("FAIL stream_budget: got %0d words expected 3000", pushed);
        end

        // Asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 32'h7700 + i);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        chk("arst_level", water_level, 0);
        chk("arst_empty", rd_empty, 1);
        chk("arst_lines", line_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jpeg_line_fifo_fwft.md
JPEG_LINE_FIFO_FWFT -- requirements
Module: jpeg_line_fifo_fwft

Interface
REQ-001 SHALL have parameter c_DATA_WIDTH, default 32, meaning word width in bits.
REQ-002 SHALL have parameter c_DEPTH_WIDTH, default 10, meaning log2 of capacity; capacity = 2^c_DEPTH_WIDTH words.
REQ-003 SHALL have parameter c_ALMOST_FULL_NUM, default 1020, meaning almost_full threshold in words.
REQ-004 SHALL have parameter c_ALMOST_EMPTY_NUM, default 4, meaning almost_empty threshold in words.
REQ-005 SHALL have parameter c_LINE_THRESH, default 8, meaning stored-line count that asserts lines_ready.
REQ-006 SHALL have the following ports (one clock; reset is asynchronous and active-low):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush.
- wr_data  in  c_DATA_WIDTH  write word.
- wr_en  in  1  write request.
- wr_eol  in  1  write word is last of a line.
- wr_full  out  1  FIFO full.
- almost_full  out  1  level >= c_ALMOST_FULL_NUM.
- rd_data  out  c_DATA_WIDTH  head word (first-word-fall-through).
- rd_eol  out  1  EOL tag of head word.
- rd_en  in  1  pop request.
- rd_empty  out  1  no valid head word.
- almost_empty  out  1  level <= c_ALMOST_EMPTY_NUM.
- water_level  out  c_DEPTH_WIDTH+1  stored words.
- line_cnt  out  c_DEPTH_WIDTH+1  stored complete lines.
- lines_ready  out  1  line_cnt >= c_LINE_THRESH.
- ovf_err  out  1  sticky overflow.
- udf_err  out  1  sticky underflow.

Function
REQ-007 SHALL accept a write when wr_en=1 and wr_full=0 at the rising edge, storing {wr_eol, wr_data}.
REQ-008 SHALL accept a read when rd_en=1 and rd_empty=0; rd_data/rd_eol valid whenever rd_empty=0, next word presented after the accepting edge.
REQ-009 SHALL deassert rd_empty two edges after the edge writing the first word into an empty FIFO (write edge + prefetch edge).
REQ-010 SHALL count water_level including the prefetched head word: +1 accepted write, -1 accepted read, unchanged when both.
REQ-011 SHALL assert wr_full exactly when water_level = 2^c_DEPTH_WIDTH; writes while full are ignored without state change.
REQ-012 SHALL ignore reads while rd_empty=1 without state change.
REQ-013 SHALL, when full with wr_en and rd_en both set, accept the read only; when empty with both set, accept the write only.
REQ-014 SHALL update line_cnt: +1 on accepted write with wr_eol=1, -1 on accepted read with rd_eol=1, unchanged when both occur.
REQ-015 SHALL derive almost_full, almost_empty, lines_ready combinationally from registered water_level/line_cnt (no extra latency).
REQ-016 SHALL wrap read and write pointers modulo 2^c_DEPTH_WIDTH without data loss.
REQ-017 SHALL, on clr=1, return all state to reset values at that edge; clr overrides concurrent wr_en/rd_en.

Reset
REQ-018 SHALL, while rst_n=0, force: pointers 0, water_level 0, line_cnt 0, rd_empty 1, wr_full 0, almost_empty 1, almost_full 0, lines_ready 0, rd_data 0, rd_eol 0, ovf_err 0, udf_err 0.
REQ-019 SHALL discard all stored data on reset or clr mid-operation; memory contents need not be cleared.

Configuration
REQ-020 SHALL, with JPEG_LINE_FIFO_ERR_EN defined, set ovf_err on a write attempted while full and udf_err on a read attempted while empty, holding both until rst_n=0 or clr=1.
REQ-021 SHALL, without JPEG_LINE_FIFO_ERR_EN, tie ovf_err and udf_err to 0 and omit their logic.

Verification
REQ-022 Reset, write 1 word 0xA5A5A5A5 -> rd_empty=0 two edges later, rd_data=0xA5A5A5A5, water_level=1.
REQ-023 Fill 1024 words (defaults), write once more -> wr_full=1, water_level=1024, extra word dropped, ovf_err=1 with macro, 0 without.
REQ-024 Full FIFO, wr_en=rd_en=1 one cycle -> water_level=1023, wr_full=0, head advances; empty FIFO same stimulus -> water_level=1, udf_err=0.
REQ-025 Write 8 lines of 16 words with wr_eol on word 16 -> line_cnt=8, lines_ready=1; pop 16 words -> line_cnt=7, lines_ready=0.
REQ-026 Stream 3000 words with random rd_en/wr_en -> output order equals input order across pointer wrap; clr mid-stream -> water_level=0, rd_empty=1 next cycle.
